cpu_fsm_param: RTL and testbench
================================

Name: cpu_fsm_param

Overview:
Parametrised CPU control FSM for the calculator datapath, second generation. Power and send buttons are synchronised and edge-detected internally. Instructions are latched and checked against a valid-opcode mask. The ALU and LCD are sequenced through explicit handshakes, and the LCD display time is held by a counter. Sits between the board buttons/switches and the ALU, register bank and LCD driver.

Parameters:
INSTR_W, 3, opcode width in bits
OP_VALID_MASK, all ones (2**INSTR_W bits), bit i set = opcode i legal
LCD_HOLD, 16, cycles spent in EXIBINDO before returning to AGUARDANDO (min 1)
TIMEOUT_CYC, 255, ALU watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
botao_ligar  in  1  raw power button, asynchronous, active-high
botao_enviar  in  1  raw send button, asynchronous, active-high
instrucao  in  INSTR_W  opcode switches
alu_done  in  1  ALU result valid, single-cycle pulse or level
lcd_ready  in  1  LCD driver idle
ligado  out  1  system powered
flag_clear  out  1  one-cycle clear pulse to datapath/LCD on power-up
instr_reg  out  INSTR_W  latched opcode
alu_start  out  1  one-cycle pulse starting the ALU
reg_we  out  1  one-cycle register-bank write enable
lcd_start  out  1  one-cycle LCD update request
erro  out  1  sticky illegal-opcode / timeout flag
estado_atual  out  4  current state encoding, for debug LEDs

Behaviour:
- Reset: state DESLIGADO; every output 0; sync flops, counters and instr_reg cleared. Reset mid-operation aborts immediately, with no pulse emitted.
- Button path: 2-flop synchroniser plus rising-edge detector. Edge pulse (ligar_p / enviar_p) occurs 3 clk after the pin rises. A held button yields one pulse only.
- Priority: ligar_p beats every other transition in every state. When ligar_p and enviar_p coincide, only ligar_p acts.
- ligar_p while ligado=0: go to LIGADO, ligado<=1.
- ligar_p while ligado=1: go to DESLIGADO, ligado<=0. In-flight operation abandoned, erro cleared, strobes forced 0.
- States and encodings:
  - DESLIGADO (0): idle; ignores enviar_p.
  - LIGADO (1): flag_clear=1 for exactly this one cycle, then AGUARDANDO.
  - AGUARDANDO (2): on enviar_p, instr_reg<=instrucao, then GRAVANDO. enviar_p in any other state is dropped; there is no queue.
  - GRAVANDO (3): one cycle, then DECODIFICANDO.
  - DECODIFICANDO (4): if OP_VALID_MASK[instr_reg]=1, clear erro, pulse alu_start, go to EXECUTANDO. Otherwise set erro and return to AGUARDANDO.
  - EXECUTANDO (5): wait for alu_done=1, then ESCREVENDO.
  - ESCREVENDO (6): reg_we=1 for this one cycle, then PREPARANDO_LCD.
  - PREPARANDO_LCD (7): wait for lcd_ready=1, pulse lcd_start, load hold counter with LCD_HOLD-1, go to EXIBINDO.
  - EXIBINDO (8): decrement counter; at 0 return to AGUARDANDO.
  - Encodings 9-15 are unreachable; if entered, recover to DESLIGADO next cycle.
- All strobes (flag_clear, alu_start, reg_we, lcd_start) are registered and never high for more than 1 cycle per transition.
- Minimum latency from enviar_p to reg_we, with alu_done already high: 4 cycles.
- erro clears on the next legal decode or on power-off.

Optional Feature:
CPU_FSM_TIMEOUT_EN:
- Defined: a counter runs in EXECUTANDO. If alu_done is not seen within TIMEOUT_CYC cycles, set erro, skip the write, and return to AGUARDANDO. The counter resets on every entry to EXECUTANDO.
- Undefined: EXECUTANDO waits indefinitely, no counter logic is generated, and TIMEOUT_CYC is unused.

Decomposition:
- Package cpu_fsm_pkg holds:
  - the state enum with fixed 4-bit encodings above;
  - the localparam ESTADO_W=4;
  - the default hold/timeout constants.
- Sub-module sincroniza_borda: 2-flop synchroniser plus rising-edge pulse, with async active-low reset. Instantiated twice.

Test Plan:
- Reset, then botao_ligar high for 10 cycles -> exactly one ligar_p; 3 cycles later LIGADO with flag_clear=1 for 1 cycle, ligado=1, then estado_atual=2.
- Powered; instrucao=3'b101, pulse botao_enviar, alu_done tied 1, lcd_ready=1, LCD_HOLD=16 -> instr_reg=5; alu_start, reg_we and lcd_start each 1 cycle in order; AGUARDANDO 16 cycles after lcd_start.
- OP_VALID_MASK=8'b0111_1111, send opcode 7 -> erro=1, no alu_start, back to AGUARDANDO. Then send opcode 2 -> erro cleared on decode.
- ligar_p while in EXECUTANDO with alu_done=0 -> DESLIGADO next cycle, ligado=0, no reg_we, erro=0.
- Simultaneous ligar/enviar edges in AGUARDANDO -> DESLIGADO; instr_reg unchanged.
- With CPU_FSM_TIMEOUT_EN and TIMEOUT_CYC=8, alu_done held 0 -> erro=1 after 8 cycles in EXECUTANDO, return to AGUARDANDO, no reg_we.

Source files
------------

// File: rtl/cpu_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Package : cpu_fsm_pkg
// Brief   : Shared state encoding and default constants for the calculator
//           CPU control FSM.
// Rev     : 1.0 - initial release
// ============================================================================
package cpu_fsm_pkg;

   localparam int ESTADO_W        = 4;
   localparam int INSTR_W_DEF     = 3;
   localparam int LCD_HOLD_DEF    = 16;
   localparam int TIMEOUT_CYC_DEF = 255;

   // Fixed encodings: they are shown on the debug LEDs, so they must not move.
   typedef enum logic [ESTADO_W-1:0] {
      DESLIGADO      = 4'd0,
      LIGADO         = 4'd1,
      AGUARDANDO     = 4'd2,
      GRAVANDO       = 4'd3,
      DECODIFICANDO  = 4'd4,
      EXECUTANDO     = 4'd5,
      ESCREVENDO     = 4'd6,
      PREPARANDO_LCD = 4'd7,
      EXIBINDO       = 4'd8
   } estado_t;

endpackage
`default_nettype wire

// File: rtl/sincroniza_borda.sv
`default_nettype none
// ============================================================================
// Module : sincroniza_borda
// Brief  : Two-flop synchroniser followed by a registered rising-edge detector.
//          The pulse appears three clocks after the raw pin rises; a held
//          input yields a single pulse.
// Rev    : 1.0 - initial release
// ============================================================================
module sincroniza_borda (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic pulso_o
);

   logic [1:0] sync_q;
   logic       prev_q;
   logic       pulso_q;

   // Synchronise the pin, remember the last synchronised level, register the edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= 2'b00;
         prev_q  <= 1'b0;
         pulso_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], async_i};
         prev_q  <= sync_q[1];
         pulso_q <= sync_q[1] & ~prev_q;
      end
   end

   assign pulso_o = pulso_q;

endmodule
`default_nettype wire

// File: rtl/cpu_fsm_param.sv
`default_nettype none
// ============================================================================
// Module : cpu_fsm_param
// Brief  : Calculator CPU control FSM. Synchronises the power/send buttons,
//          latches and validates the opcode, and sequences ALU, register
//          write and LCD update through handshakes with a display hold timer.
// Config : define CPU_FSM_TIMEOUT_EN to add an ALU watchdog of TIMEOUT_CYC
//          cycles in EXECUTANDO (undefined: wait for alu_done forever).
// Rev    : 1.0 - initial release
// ============================================================================
module cpu_fsm_param
   import cpu_fsm_pkg::*;
#(
   parameter int                    INSTR_W       = INSTR_W_DEF,
   parameter logic [2**INSTR_W-1:0] OP_VALID_MASK = '1,
   parameter int                    LCD_HOLD      = LCD_HOLD_DEF,
   parameter int                    TIMEOUT_CYC   = TIMEOUT_CYC_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                botao_ligar,
   input  logic                botao_enviar,
   input  logic [INSTR_W-1:0]  instrucao,
   input  logic                alu_done,
   input  logic                lcd_ready,
   output logic                ligado,
   output logic                flag_clear,
   output logic [INSTR_W-1:0]  instr_reg,
   output logic                alu_start,
   output logic                reg_we,
   output logic                lcd_start,
   output logic                erro,
   output logic [ESTADO_W-1:0] estado_atual
);

   localparam int                HOLD_W    = (LCD_HOLD > 1) ? $clog2(LCD_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(LCD_HOLD - 1);

   logic ligar_p;
   logic enviar_p;

   estado_t              state_q,      state_d;
   logic                 ligado_q,     ligado_d;
   logic                 flag_clear_q, flag_clear_d;
   logic                 alu_start_q,  alu_start_d;
   logic                 reg_we_q,     reg_we_d;
   logic                 lcd_start_q,  lcd_start_d;
   logic                 erro_q,       erro_d;
   logic [INSTR_W-1:0]   instr_q,      instr_d;
   logic [HOLD_W-1:0]    hold_q,       hold_d;
   logic                 opcode_ok;

   sincroniza_borda u_sync_ligar (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (botao_ligar),
      .pulso_o (ligar_p)
   );

   sincroniza_borda u_sync_enviar (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (botao_enviar),
      .pulso_o (enviar_p)
   );

   assign opcode_ok = OP_VALID_MASK[instr_q];

`ifdef CPU_FSM_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            to_expired;

   // Last permitted cycle in EXECUTANDO without alu_done
   assign to_expired = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

   // Watchdog count: restart on entry to EXECUTANDO, advance while there
   always_comb begin
      to_cnt_d = to_cnt_q;
      if ((state_d == EXECUTANDO) && (state_q != EXECUTANDO)) begin
         to_cnt_d = '0;
      end else if (state_q == EXECUTANDO) begin
         to_cnt_d = to_cnt_q + TO_W'(1);
      end
   end

   // Watchdog register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_d;
      end
   end
`else
   logic timeout_unused;
   assign timeout_unused = (TIMEOUT_CYC != 0);
`endif

   // Next state: a power edge overrides every other transition
   always_comb begin
      state_d = state_q;
      if (ligar_p) begin
         state_d = ligado_q ? DESLIGADO : LIGADO;
      end else begin
         case (state_q)
            DESLIGADO:      state_d = DESLIGADO;
            LIGADO:         state_d = AGUARDANDO;
            AGUARDANDO:     if (enviar_p) state_d = GRAVANDO;
            GRAVANDO:       state_d = DECODIFICANDO;
            DECODIFICANDO:  state_d = opcode_ok ? EXECUTANDO : AGUARDANDO;
            EXECUTANDO: begin
               if (alu_done) begin
                  state_d = ESCREVENDO;
               end
`ifdef CPU_FSM_TIMEOUT_EN
               else if (to_expired) begin
                  state_d = AGUARDANDO;
               end
`endif
            end
            ESCREVENDO:     state_d = PREPARANDO_LCD;
            PREPARANDO_LCD: if (lcd_ready) state_d = EXIBINDO;
            EXIBINDO:       if (hold_q == '0) state_d = AGUARDANDO;
            default:        state_d = DESLIGADO;
         endcase
      end
   end

   // Outputs and datapath registers derived from the chosen transition, so
   // every strobe is registered and vanishes when power-off wins
   always_comb begin
      ligado_d     = (state_d != DESLIGADO);
      flag_clear_d = (state_d == LIGADO);
      alu_start_d  = (state_q == DECODIFICANDO) && (state_d == EXECUTANDO);
      reg_we_d     = (state_d == ESCREVENDO);
      lcd_start_d  = (state_q == PREPARANDO_LCD) && (state_d == EXIBINDO);

      instr_d = instr_q;
      if ((state_q == AGUARDANDO) && (state_d == GRAVANDO)) begin
         instr_d = instrucao;
      end

      erro_d = erro_q;
      if (state_d == DESLIGADO) begin
         erro_d = 1'b0;
      end else if ((state_q == DECODIFICANDO) && (state_d == EXECUTANDO)) begin
         erro_d = 1'b0;
      end else if ((state_q == DECODIFICANDO) && (state_d == AGUARDANDO)) begin
         erro_d = 1'b1;
      end else if ((state_q == EXECUTANDO) && (state_d == AGUARDANDO)) begin
         erro_d = 1'b1;
      end

      hold_d = hold_q;
      if (lcd_start_d) begin
         hold_d = HOLD_LOAD;
      end else if ((state_q == EXIBINDO) && (hold_q != '0)) begin
         hold_d = hold_q - HOLD_W'(1);
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= DESLIGADO;
         ligado_q     <= 1'b0;
         flag_clear_q <= 1'b0;
         alu_start_q  <= 1'b0;
         reg_we_q     <= 1'b0;
         lcd_start_q  <= 1'b0;
         erro_q       <= 1'b0;
         instr_q      <= '0;
         hold_q       <= '0;
      end else begin
         state_q      <= state_d;
         ligado_q     <= ligado_d;
         flag_clear_q <= flag_clear_d;
         alu_start_q  <= alu_start_d;
         reg_we_q     <= reg_we_d;
         lcd_start_q  <= lcd_start_d;
         erro_q       <= erro_d;
         instr_q      <= instr_d;
         hold_q       <= hold_d;
      end
   end

   assign ligado       = ligado_q;
   assign flag_clear   = flag_clear_q;
   assign instr_reg    = instr_q;
   assign alu_start    = alu_start_q;
   assign reg_we       = reg_we_q;
   assign lcd_start    = lcd_start_q;
   assign erro         = erro_q;
   assign estado_atual = state_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_fsm_param.sv
`default_nettype none
// ============================================================================
// Module : tb_cpu_fsm_param
// Brief  : Scoreboard bench for cpu_fsm_param. Stimulus queues the expected
//          strobe/flag events; a monitor pops and compares them whenever the
//          DUT raises a strobe or changes ligado/erro.
// Config : CPU_FSM_TIMEOUT_EN additionally runs the ALU watchdog scenario.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cpu_fsm_param;

   logic       clk          = 1'b0;
   logic       rst_n        = 1'b0;
   logic       botao_ligar  = 1'b0;
   logic       botao_enviar = 1'b0;
   logic [2:0] instrucao    = 3'd0;
   logic       alu_done     = 1'b0;
   logic       lcd_ready    = 1'b0;
   logic       ligado, flag_clear, alu_start, reg_we, lcd_start, erro;
   logic [2:0] instr_reg;
   logic [3:0] estado_atual;

   cpu_fsm_param #(
      .INSTR_W       (3),
      .OP_VALID_MASK (8'b0111_1111),
      .LCD_HOLD      (16),
      .TIMEOUT_CYC   (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .botao_ligar  (botao_ligar),
      .botao_enviar (botao_enviar),
      .instrucao    (instrucao),
      .alu_done     (alu_done),
      .lcd_ready    (lcd_ready),
      .ligado       (ligado),
      .flag_clear   (flag_clear),
      .instr_reg    (instr_reg),
      .alu_start    (alu_start),
      .reg_we       (reg_we),
      .lcd_start    (lcd_start),
      .erro         (erro),
      .estado_atual (estado_atual)
   );

   always #5 clk = ~clk;

   // Event word: {flag_clear, alu_start, reg_we, lcd_start, ligado, erro, estado}
   typedef logic [9:0] ev_t;

   ev_t exp_q[$];
   int  n_checks = 0;
   int  n_fail   = 0;
   bit  mon_en   = 1'b0;
   int  n_cyc;

   function automatic ev_t mk(input bit fc, input bit as, input bit we,
                              input bit ls, input bit lig, input bit er,
                              input logic [3:0] st);
      return {fc, as, we, ls, lig, er, st};
   endfunction

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] req);
      n_checks++;
      if (got !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", name, got, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Count edges until the state appears; buttons are released after 2 edges
   task automatic wait_state(input logic [3:0] target, input int max_cyc,
                             input bit drop_btns, output int n);
      n = 0;
      do begin
         tick();
         n++;
         if (drop_btns && n == 2) begin
            botao_ligar  = 1'b0;
            botao_enviar = 1'b0;
         end
      end while (estado_atual != target && n < max_cyc);
      if (estado_atual != target) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_state: got state %0d after %0d cycles, required %0d",
                  estado_atual, n, target);
      end
   endtask

   // Scoreboard monitor
   initial begin : monitor
      logic prev_lig, prev_erro;
      ev_t  got, want;
      prev_lig  = 1'b0;
      prev_erro = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (mon_en) begin
            got = {flag_clear, alu_start, reg_we, lcd_start, ligado, erro, estado_atual};
            if (flag_clear || alu_start || reg_we || lcd_start ||
                (ligado != prev_lig) || (erro != prev_erro)) begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL sb_unexpected: got event %b, required no event", got);
               end else begin
                  want = exp_q.pop_front();
                  if (got !== want) begin
                     n_fail++;
                     $display("FAIL sb_event: got %b required %b", got, want);
                  end
               end
            end
         end
         prev_lig  = ligado;
         prev_erro = erro;
      end
   end

   // Global time limit
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   // Directed stimulus
   initial begin
      rst_n = 1'b0;
      repeat (3) tick();
      check("rst_estado", 32'(estado_atual), 32'd0);
      check("rst_ligado", 32'(ligado), 32'd0);
      check("rst_strobes", 32'({flag_clear, alu_start, reg_we, lcd_start}), 32'd0);
      check("rst_instr", 32'(instr_reg), 32'd0);
      check("rst_erro", 32'(erro), 32'd0);
      @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Power-on with a long button hold: one edge only
      exp_q.push_back(mk(1, 0, 0, 0, 1, 0, 4'd1));
      @(negedge clk) botao_ligar = 1'b1;
      wait_state(4'd1, 20, 1'b0, n_cyc);
      check("pwr_on_latency", 32'(n_cyc), 32'd4);
      tick();
      check("pwr_on_aguard", 32'(estado_atual), 32'd2);
      check("pwr_on_fc_low", 32'(flag_clear), 32'd0);
      repeat (6) tick();
      @(negedge clk) botao_ligar = 1'b0;
      repeat (6) tick();
      check("held_btn_still_on", 32'({ligado, estado_atual}), 32'h12);

      // Legal opcode 5 with ALU and LCD ready
      alu_done  = 1'b1;
      lcd_ready = 1'b1;
      instrucao = 3'd5;
      exp_q.push_back(mk(0, 1, 0, 0, 1, 0, 4'd5));
      exp_q.push_back(mk(0, 0, 1, 0, 1, 0, 4'd6));
      exp_q.push_back(mk(0, 0, 0, 1, 1, 0, 4'd8));
      @(negedge clk) botao_enviar = 1'b1;
      wait_state(4'd6, 30, 1'b1, n_cyc);
      check("send_to_reg_we", 32'(n_cyc), 32'd7);
      check("instr_reg_5", 32'(instr_reg), 32'd5);
      wait_state(4'd8, 10, 1'b0, n_cyc);
      wait_state(4'd2, 40, 1'b0, n_cyc);
      check("lcd_hold_cycles", 32'(n_cyc), 32'd16);

      // Illegal opcode 7 sets erro; legal opcode 2 clears it on decode
      instrucao = 3'd7;
      exp_q.push_back(mk(0, 0, 0, 0, 1, 1, 4'd2));
      @(negedge clk) botao_enviar = 1'b1;
      wait_state(4'd4, 20, 1'b1, n_cyc);
      tick();
      check("illegal_state", 32'(estado_atual), 32'd2);
      check("illegal_erro", 32'(erro), 32'd1);
      check("illegal_instr", 32'(instr_reg), 32'd7);
      instrucao = 3'd2;
      exp_q.push_back(mk(0, 1, 0, 0, 1, 0, 4'd5));
      exp_q.push_back(mk(0, 0, 1, 0, 1, 0, 4'd6));
      exp_q.push_back(mk(0, 0, 0, 1, 1, 0, 4'd8));
      @(negedge clk) botao_enviar = 1'b1;
      wait_state(4'd5, 20, 1'b1, n_cyc);
      check("legal_erro_clear", 32'(erro), 32'd0);
      wait_state(4'd2, 60, 1'b0, n_cyc);

      // Power-off while the ALU is still busy
      alu_done  = 1'b0;
      instrucao = 3'd3;
      exp_q.push_back(mk(0, 1, 0, 0, 1, 0, 4'd5));
      @(negedge clk) botao_enviar = 1'b1;
      wait_state(4'd5, 20, 1'b1, n_cyc);
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 4'd0));
      @(negedge clk) botao_ligar = 1'b1;
      wait_state(4'd0, 20, 1'b1, n_cyc);
      check("off_in_exec_latency", 32'(n_cyc), 32'd4);
      repeat (4) tick();
      check("off_in_exec_idle", 32'({ligado, erro, estado_atual}), 32'd0);

      // Power on, raise erro, then simultaneous power/send edges
      exp_q.push_back(mk(1, 0, 0, 0, 1, 0, 4'd1));
      @(negedge clk) botao_ligar = 1'b1;
      wait_state(4'd2, 20, 1'b1, n_cyc);
      instrucao = 3'd7;
      exp_q.push_back(mk(0, 0, 0, 0, 1, 1, 4'd2));
      @(negedge clk) botao_enviar = 1'b1;
      wait_state(4'd4, 20, 1'b1, n_cyc);
      tick();
      instrucao = 3'd6;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 4'd0));
      @(negedge clk);
      botao_ligar  = 1'b1;
      botao_enviar = 1'b1;
      wait_state(4'd0, 20, 1'b1, n_cyc);
      repeat (4) tick();
      check("simul_instr_kept", 32'(instr_reg), 32'd7);
      check("simul_off", 32'({ligado, erro, estado_atual}), 32'd0);

`ifdef CPU_FSM_TIMEOUT_EN
      // ALU never answers: watchdog expires after 8 cycles in EXECUTANDO
      exp_q.push_back(mk(1, 0, 0, 0, 1, 0, 4'd1));
      @(negedge clk) botao_ligar = 1'b1;
      wait_state(4'd2, 20, 1'b1, n_cyc);
      alu_done  = 1'b0;
      instrucao = 3'd4;
      exp_q.push_back(mk(0, 1, 0, 0, 1, 0, 4'd5));
      exp_q.push_back(mk(0, 0, 0, 0, 1, 1, 4'd2));
      @(negedge clk) botao_enviar = 1'b1;
      wait_state(4'd5, 20, 1'b1, n_cyc);
      wait_state(4'd2, 40, 1'b0, n_cyc);
      check("timeout_cycles", 32'(n_cyc), 32'd8);
      check("timeout_erro", 32'(erro), 32'd1);
`endif

      repeat (6) tick();
      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
